// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for a VGA sync stream. Samples hs/vs/blank
// on the pixel strobe, recovers visible pixel coordinates, measures line and frame
// timing, declares lock after LOCK_FRAMES stable frames and pulses err on loss of
// lock or on an hs timeout.
// Optional feature: define VGA_MON_STATS_EN to add the frame_cnt/err_cnt outputs.
module vga_sync_monitor #(
  parameter int   HW          = 12,
  parameter int   VW          = 11,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank,
  output logic          pix_valid,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked,
  output logic          err
`ifdef VGA_MON_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_MAX  = {HW{1'b1}};
  localparam logic [HW-1:0] H_TMO  = H_MAX - H_ONE;
  localparam logic [VW-1:0] V_ONE  = VW'(1);
  localparam logic [VW-1:0] V_MAX  = {VW{1'b1}};
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (v == H_MAX) ? v : v + H_ONE;
  endfunction

  function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
    return (v == V_MAX) ? v : v + V_ONE;
  endfunction

  function automatic logic [3:0] sat_inc_4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic          r_vld_p0, r_hs_p0, r_vs_p0, r_blank_p0;
  logic          r_hs_act, r_vs_act;
  logic [HW-1:0] r_hc, r_act_cnt, r_line_len, r_hact, r_prev_len, r_prev_act;
  logic [VW-1:0] r_vc, r_vis_cnt, r_prev_lines, r_prev_vis;
  logic [3:0]    r_stable;
  state_t        r_state;
  logic          r_locked, r_err, r_pix_valid;
  logic [HW-1:0] r_pix_x, r_h_total, r_h_active;
  logic [VW-1:0] r_pix_y, r_v_total, r_v_active;

  logic          w_hs_on, w_vs_on, w_lead_hs, w_lead_vs, w_line_vis;
  logic          w_timeout, w_line_bad, w_frame_bad, w_match;
  logic [HW-1:0] w_hc_inc, w_line_len, w_hact, w_act_base;
  logic [VW-1:0] w_vc_hs, w_vis_hs, w_vis_base;
  logic [3:0]    w_stable_try, w_stable_n;
  state_t        w_state_n;
  logic          w_err_n, w_load;

  // ---- stage p0: input sampling ----
  // Register the raw inputs once; only the strobe is reset so stale data is ignored.
  always_ff @(posedge clk50m) begin
    r_hs_p0    <= vga_hs;
    r_vs_p0    <= vga_vs;
    r_blank_p0 <= vga_blank;
    if (!rst_n) r_vld_p0 <= 1'b0;
    else        r_vld_p0 <= pix_en;
  end

  // ---- stage p1: edge detection and counter next-values ----
  assign w_hs_on    = (r_hs_p0 == HS_POL);
  assign w_vs_on    = (r_vs_p0 == VS_POL);
  assign w_lead_hs  = r_vld_p0 & w_hs_on & ~r_hs_act;
  assign w_lead_vs  = r_vld_p0 & w_vs_on & ~r_vs_act;
  assign w_hc_inc   = sat_inc_h(r_hc);
  assign w_line_len = w_lead_hs ? w_hc_inc : r_line_len;
  // A finished line counts as visible when it held at least one visible tick.
  assign w_line_vis = w_lead_hs & (r_act_cnt != '0);
  assign w_hact     = w_line_vis ? r_act_cnt : r_hact;
  assign w_act_base = w_lead_hs ? '0 : r_act_cnt;
  // hs-edge update first, vs-edge update on top of it when both land together.
  assign w_vc_hs    = w_lead_hs ? sat_inc_v(r_vc) : r_vc;
  assign w_vis_hs   = w_line_vis ? sat_inc_v(r_vis_cnt) : r_vis_cnt;
  assign w_vis_base = w_lead_vs ? '0 : w_vis_hs;
  // Timeout fires once, on the tick that drives hc into saturation.
  assign w_timeout  = r_vld_p0 & ~w_lead_hs & (r_hc == H_TMO);
  assign w_line_bad = w_lead_hs & ((w_line_len != r_h_total) |
                                   (w_line_vis & (r_act_cnt != r_h_active)));
  assign w_frame_bad = w_lead_vs & ((w_vc_hs != r_v_total) | (w_vis_hs != r_v_active));
  assign w_match    = (w_line_len == r_prev_len) & (w_hact == r_prev_act) &
                      (w_vc_hs == r_prev_lines) & (w_vis_hs == r_prev_vis);
  assign w_stable_try = w_match ? sat_inc_4(r_stable) : 4'd1;

  // Line/frame counters and previous-frame snapshot, advanced on pixel ticks only.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_hs_act     <= 1'b0;
      r_vs_act     <= 1'b0;
      r_hc         <= '0;
      r_act_cnt    <= '0;
      r_line_len   <= '0;
      r_hact       <= '0;
      r_vc         <= '0;
      r_vis_cnt    <= '0;
      r_prev_len   <= '0;
      r_prev_act   <= '0;
      r_prev_lines <= '0;
      r_prev_vis   <= '0;
    end else if (r_vld_p0) begin
      r_hs_act   <= w_hs_on;
      r_vs_act   <= w_vs_on;
      r_hc       <= w_lead_hs ? '0 : w_hc_inc;
      r_line_len <= w_line_len;
      r_hact     <= w_hact;
      r_act_cnt  <= r_blank_p0 ? sat_inc_h(w_act_base) : w_act_base;
      r_vc       <= w_lead_vs ? '0 : w_vc_hs;
      r_vis_cnt  <= w_vis_base;
      if (w_lead_vs) begin
        r_prev_len   <= w_line_len;
        r_prev_act   <= w_hact;
        r_prev_lines <= w_vc_hs;
        r_prev_vis   <= w_vis_hs;
      end
    end
  end

  // FSM state and stability counter.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_state  <= ST_SEARCH;
      r_stable <= '0;
    end else begin
      r_state  <= w_state_n;
      r_stable <= w_stable_n;
    end
  end

  // FSM next state, lock load and err decision.
  always_comb begin
    w_state_n  = r_state;
    w_stable_n = r_stable;
    w_err_n    = 1'b0;
    w_load     = 1'b0;
    if (r_vld_p0) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_timeout) begin
            w_err_n = 1'b1;
          end else if (w_lead_vs) begin
            w_state_n  = ST_MEASURE;
            w_stable_n = '0;
          end
        end
        ST_MEASURE: begin
          if (w_timeout) begin
            w_err_n   = 1'b1;
            w_state_n = ST_SEARCH;
          end else if (w_lead_vs) begin
            w_stable_n = w_stable_try;
            if (w_stable_try >= LOCK_N) begin
              w_load    = 1'b1;
              w_state_n = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_timeout | w_line_bad | w_frame_bad) begin
            w_err_n   = 1'b1;
            w_state_n = ST_SEARCH;
          end
        end
        default: w_state_n = ST_SEARCH;
      endcase
    end
  end

  // ---- stage p2: registered outputs ----
  // Measurements load on lock and hold; pixel outputs refresh on each tick.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_h_total   <= '0;
      r_h_active  <= '0;
      r_v_total   <= '0;
      r_v_active  <= '0;
    end else begin
      r_locked <= (w_state_n == ST_LOCKED);
      r_err    <= w_err_n;
      if (w_load) begin
        r_h_total  <= w_line_len;
        r_h_active <= w_hact;
        r_v_total  <= w_vc_hs;
        r_v_active <= w_vis_hs;
      end
      if (r_vld_p0) begin
        r_pix_valid <= r_locked & r_blank_p0;
        r_pix_x     <= w_act_base;
        r_pix_y     <= w_vis_base;
      end
    end
  end

  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign h_total   = r_h_total;
  assign h_active  = r_h_active;
  assign v_total   = r_v_total;
  assign v_active  = r_v_active;
  assign locked    = r_locked;
  assign err       = r_err;

`ifdef VGA_MON_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_err_cnt;

  // Frame counter wraps; error counter saturates.
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_lead_vs && (r_state == ST_LOCKED)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err_n && (r_err_cnt != 8'hFF))      r_err_cnt   <= r_err_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down video format
// (40 px/line, 6 px hs, 28 visible; 12 lines/frame, 2 vs lines, 8 visible).
`timescale 1ns/1ps
module tb_vga_sync_monitor;
  localparam int HW = 12, VW = 11;
  localparam int H_TOT = 40, HS_W = 6, H_ST = 8, H_ACT = 28;
  localparam int V_TOT = 12, VS_W = 2, V_ST = 3, V_ACT = 8;

  logic          clk50m = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  logic          vga_hs = 1'b1, vga_vs = 1'b1, vga_blank = 1'b0;
  logic          pix_valid, locked, err;
  logic [HW-1:0] pix_x, h_total, h_active;
  logic [VW-1:0] pix_y, v_total, v_active;
`ifdef VGA_MON_STATS_EN
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
`endif

  int n_chk = 0, n_pass = 0, err_seen = 0, vld_seen = 0;

  vga_sync_monitor #(.HW(HW), .VW(VW), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .pix_en(pix_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .err(err)
`ifdef VGA_MON_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #10 clk50m = ~clk50m;

  always @(negedge clk50m) begin
    if (err === 1'b1) err_seen++;
    if (pix_valid === 1'b1) vld_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  function automatic logic vis_at(input int ln, input int x);
    return (ln >= V_ST) && (ln < V_ST + V_ACT) && (x >= H_ST) && (x < H_ST + H_ACT);
  endfunction

  // One pixel strobe; starts and ends on a falling clock edge, so outputs of this
  // tick are visible on return.
  task automatic tick(input logic hs, input logic vs, input logic blank);
    vga_hs = hs; vga_vs = vs; vga_blank = blank; pix_en = 1'b1;
    @(negedge clk50m);
    pix_en = 1'b0;
    @(negedge clk50m);
  endtask

  task automatic drive_span(input int ln, input int x0, input int x1);
    for (int x = x0; x < x1; x++)
      tick((x < HS_W) ? 1'b0 : 1'b1, (ln < VS_W) ? 1'b0 : 1'b1, vis_at(ln, x));
  endtask

  task automatic drive_lines(input int ln0, input int ln1, input int stretch_ln);
    for (int ln = ln0; ln < ln1; ln++)
      drive_span(ln, 0, (ln == stretch_ln) ? H_TOT + 1 : H_TOT);
  endtask

  task automatic drive_frames(input int n);
    for (int f = 0; f < n; f++) drive_lines(0, V_TOT, -1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk50m);
    n_chk++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_chk++; if ({pix_valid, pix_x, pix_y} !== '0)
      $display("FAIL reset_pix: got v=%b x=%0d y=%0d want 0", pix_valid, pix_x, pix_y); else n_pass++;
    n_chk++; if ({h_total, h_active, v_total, v_active} !== '0)
      $display("FAIL reset_meas: got %0d %0d %0d %0d want 0", h_total, h_active, v_total, v_active); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk50m);
  endtask

  task automatic test_lock;
    drive_frames(2);
    n_chk++; if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0", locked); else n_pass++;
    n_chk++; if (vld_seen !== 0) $display("FAIL unlocked_valid: got %0d want 0", vld_seen); else n_pass++;
    drive_span(0, 0, 1);
    n_chk++; if (locked !== 1'b1) $display("FAIL lock_third_vs: got %b want 1", locked); else n_pass++;
    drive_span(0, 1, H_TOT);
    drive_lines(1, V_TOT, -1);
    n_chk++; if (h_total !== 12'd40) $display("FAIL h_total: got %0d want 40", h_total); else n_pass++;
    n_chk++; if (h_active !== 12'd28) $display("FAIL h_active: got %0d want 28", h_active); else n_pass++;
    n_chk++; if (v_total !== 11'd12) $display("FAIL v_total: got %0d want 12", v_total); else n_pass++;
    n_chk++; if (v_active !== 11'd8) $display("FAIL v_active: got %0d want 8", v_active); else n_pass++;
  endtask

  task automatic test_pixels;
    int v0, e0;
    v0 = vld_seen; e0 = err_seen;
    for (int ln = 0; ln < V_TOT; ln++) begin
      for (int x = 0; x < H_TOT; x++) begin
        tick((x < HS_W) ? 1'b0 : 1'b1, (ln < VS_W) ? 1'b0 : 1'b1, vis_at(ln, x));
        if (ln == V_ST && x == H_ST) begin
          n_chk++; if (pix_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", pix_valid); else n_pass++;
          n_chk++; if (pix_x !== 12'd0) $display("FAIL first_x: got %0d want 0", pix_x); else n_pass++;
          n_chk++; if (pix_y !== 11'd0) $display("FAIL first_y: got %0d want 0", pix_y); else n_pass++;
        end
        if (ln == V_ST && x == H_ST + H_ACT) begin
          n_chk++; if (pix_valid !== 1'b0) $display("FAIL porch_valid: got %b want 0", pix_valid); else n_pass++;
        end
        if (ln == V_ST + V_ACT - 1 && x == H_ST + H_ACT - 1) begin
          n_chk++; if (pix_x !== 12'd27) $display("FAIL last_x: got %0d want 27", pix_x); else n_pass++;
          n_chk++; if (pix_y !== 11'd7) $display("FAIL last_y: got %0d want 7", pix_y); else n_pass++;
        end
      end
    end
    n_chk++; if (vld_seen - v0 !== 2 * H_ACT * V_ACT)
      $display("FAIL valid_count: got %0d want %0d", vld_seen - v0, 2 * H_ACT * V_ACT); else n_pass++;
    n_chk++; if (err_seen - e0 !== 0) $display("FAIL clean_err: got %0d want 0", err_seen - e0); else n_pass++;
  endtask

  task automatic test_stretch;
    int e0;
    e0 = err_seen;
    drive_lines(0, V_TOT, 5);
    n_chk++; if (err_seen - e0 !== 1) $display("FAIL stretch_err: got %0d want 1", err_seen - e0); else n_pass++;
    n_chk++; if (locked !== 1'b0) $display("FAIL stretch_unlock: got %b want 0", locked); else n_pass++;
    drive_frames(2);
    n_chk++; if (locked !== 1'b0) $display("FAIL stretch_relock_early: got %b want 0", locked); else n_pass++;
    drive_frames(1);
    n_chk++; if (locked !== 1'b1) $display("FAIL stretch_relock: got %b want 1", locked); else n_pass++;
    n_chk++; if (err_seen - e0 !== 1) $display("FAIL stretch_err_once: got %0d want 1", err_seen - e0); else n_pass++;
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_seen;
    for (int k = 0; k < 4100; k++) tick(1'b1, 1'b1, 1'b0);
    n_chk++; if (err_seen - e0 !== 1) $display("FAIL timeout_err: got %0d want 1", err_seen - e0); else n_pass++;
    n_chk++; if (locked !== 1'b0) $display("FAIL timeout_unlock: got %b want 0", locked); else n_pass++;
  endtask

  task automatic test_midreset;
    drive_frames(3);
    drive_lines(0, 5, -1);
    n_chk++; if (locked !== 1'b1) $display("FAIL prereset_locked: got %b want 1", locked); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk50m);
    rst_n = 1'b1;
    n_chk++; if (locked !== 1'b0) $display("FAIL midreset_locked: got %b want 0", locked); else n_pass++;
    n_chk++; if ({err, pix_valid, pix_x, pix_y} !== '0)
      $display("FAIL midreset_pix: got e=%b v=%b x=%0d y=%0d want 0", err, pix_valid, pix_x, pix_y); else n_pass++;
    n_chk++; if ({h_total, h_active, v_total, v_active} !== '0)
      $display("FAIL midreset_meas: got %0d %0d %0d %0d want 0", h_total, h_active, v_total, v_active); else n_pass++;
    drive_frames(2);
    n_chk++; if (locked !== 1'b0) $display("FAIL relock_early: got %b want 0", locked); else n_pass++;
    drive_frames(1);
    n_chk++; if (locked !== 1'b1) $display("FAIL relock: got %b want 1", locked); else n_pass++;
    n_chk++; if (h_total !== 12'd40 || v_active !== 11'd8)
      $display("FAIL relock_meas: got %0d/%0d want 40/8", h_total, v_active); else n_pass++;
  endtask

`ifdef VGA_MON_STATS_EN
  task automatic test_stats;
    int e0;
    e0 = err_seen;
    drive_frames(10);
    n_chk++; if (frame_cnt < 16'd10) $display("FAIL frame_cnt: got %0d want >=10", frame_cnt); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive_lines(0, V_TOT, 5);
      drive_frames(3);
    end
    n_chk++; if (err_cnt !== 8'd3) $display("FAIL err_cnt: got %0d want 3", err_cnt); else n_pass++;
    n_chk++; if (err_seen - e0 !== 3) $display("FAIL stats_err_pulses: got %0d want 3", err_seen - e0); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_stretch();
    test_timeout();
    test_midreset();
`ifdef VGA_MON_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
